// File: rtl/color_detect_pkg.sv
// Shared types and frame constants for the colour-detect video path.
//  FRAME_H / FRAME_V / FRAME_PIXELS : nominal 640x360 frame geometry
//  PIX_W, pix_t                     : RGB565 pixel word
//  pix_beat_t                       : pixel plus start-of-frame / end-of-line sideband
//  rd_state_e                       : frame-buffer reader FSM states
package color_detect_pkg;

  localparam int FRAME_H      = 640;
  localparam int FRAME_V      = 360;
  localparam int FRAME_PIXELS = FRAME_H * FRAME_V;
  localparam int PIX_W        = 16;

  typedef logic [PIX_W-1:0] pix_t;

  typedef struct packed {
    pix_t data;
    logic sof;
    logic eol;
  } pix_beat_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_e;

  // Bundle a pixel with its sideband bits.
  function automatic pix_beat_t make_beat(input pix_t data, input logic sof, input logic eol);
    pix_beat_t beat;
    beat.data = data;
    beat.sof  = sof;
    beat.eol  = eol;
    return beat;
  endfunction

endpackage

// File: rtl/pix_skid_fifo.sv
// Two-entry synchronous FIFO of pixel beats. The head entry is held in a
// register that drives the output stream directly, so data/sideband stay
// stable while the consumer stalls.
//  i_clk, i_rstn     : clock, asynchronous active-low reset
//  i_clr             : synchronous clear (drops both entries)
//  i_wr_en/i_wr_beat : push one beat
//  i_rd_ready        : consumer ready; a pop happens when o_rd_valid & i_rd_ready
//  o_rd_valid/beat   : head of the FIFO
//  o_free            : slots available for a push arriving after this cycle,
//                      i.e. empty slots plus the one freed by this cycle's pop
module pix_skid_fifo
  import color_detect_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_clr,
  input  logic       i_wr_en,
  input  pix_beat_t  i_wr_beat,
  input  logic       i_rd_ready,
  output logic       o_rd_valid,
  output pix_beat_t  o_rd_beat,
  output logic [1:0] o_free
);

  pix_beat_t head_r;
  pix_beat_t tail_r;
  logic      head_vld_r;
  logic      tail_vld_r;

  pix_beat_t head_n_s;
  pix_beat_t tail_n_s;
  logic      head_vld_n_s;
  logic      tail_vld_n_s;
  logic      pop_s;
  logic [1:0] count_s;

  // Next-state of the two slots: pop first (tail shifts into head), then push into the first free slot.
  always_comb begin
    pop_s        = head_vld_r & i_rd_ready;
    count_s      = {1'b0, head_vld_r} + {1'b0, tail_vld_r};
    o_free       = 2'd2 - count_s + {1'b0, pop_s};
    head_n_s     = head_r;
    tail_n_s     = tail_r;
    head_vld_n_s = head_vld_r;
    tail_vld_n_s = tail_vld_r;
    if (pop_s) begin
      if (tail_vld_r) begin
        head_n_s     = tail_r;
        head_vld_n_s = 1'b1;
        tail_vld_n_s = 1'b0;
      end else begin
        head_vld_n_s = 1'b0;
      end
    end else begin
      head_vld_n_s = head_vld_r;
    end
    if (i_wr_en) begin
      if (!head_vld_n_s) begin
        head_n_s     = i_wr_beat;
        head_vld_n_s = 1'b1;
      end else begin
        tail_n_s     = i_wr_beat;
        tail_vld_n_s = 1'b1;
      end
    end else begin
      tail_vld_n_s = tail_vld_n_s;
    end
  end

  // Slot storage with async reset and synchronous clear.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      head_r     <= '0;
      tail_r     <= '0;
      head_vld_r <= 1'b0;
      tail_vld_r <= 1'b0;
    end else if (i_clr) begin
      head_r     <= '0;
      tail_r     <= '0;
      head_vld_r <= 1'b0;
      tail_vld_r <= 1'b0;
    end else begin
      head_r     <= head_n_s;
      tail_r     <= tail_n_s;
      head_vld_r <= head_vld_n_s;
      tail_vld_r <= tail_vld_n_s;
    end
  end

  assign o_rd_valid = head_vld_r;
  assign o_rd_beat  = head_r;

endmodule

// File: rtl/fbuf_reader.sv
// Read-side master of the frame buffer. On i_start it scans the frame once in
// raster order, hides the 1-cycle BRAM latency and emits a valid/ready pixel
// stream with start-of-frame (o_tuser) and end-of-line (o_tlast) markers.
//  i_clk, i_rstn        : clock, asynchronous active-low reset
//  i_start              : begin a frame scan (ignored while busy or with i_flush)
//  i_flush              : synchronous abort back to idle
//  o_raddr / i_rdata    : BRAM read port, data valid one cycle after the address
//  o_tdata/tvalid/tuser/tlast, i_tready : output pixel stream
//  o_busy               : scan in progress (issuing or draining)
//  o_done               : one-cycle pulse after the final pixel handshake
// DATA_WIDTH is expected to equal PIX_W.
module fbuf_reader
  import color_detect_pkg::*;
#(
  parameter int DATA_WIDTH = PIX_W,
  parameter int H_ACTIVE   = FRAME_H,
  parameter int V_ACTIVE   = FRAME_V,
  parameter int ADDR_WIDTH = 18
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_start,
  input  logic                  i_flush,
  output logic [ADDR_WIDTH-1:0] o_raddr,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  output logic [DATA_WIDTH-1:0] o_tdata,
  output logic                  o_tvalid,
  input  logic                  i_tready,
  output logic                  o_tuser,
  output logic                  o_tlast,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int FRAME_PIX = H_ACTIVE * V_ACTIVE;
  localparam int X_W = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int Y_W = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_PIX - 1);
  localparam logic [X_W-1:0]        X_LAST    = X_W'(H_ACTIVE - 1);
  localparam logic [Y_W-1:0]        Y_LAST    = Y_W'(V_ACTIVE - 1);

  rd_state_e             state_r;
  rd_state_e             state_nxt_s;
  logic [ADDR_WIDTH-1:0] raddr_r;
  logic [X_W-1:0]        x_r;
  logic [Y_W-1:0]        y_r;
  logic                  inflight_r;
  logic                  inflight_sof_r;
  logic                  inflight_eol_r;
  logic                  busy_r;
  logic                  done_r;

  logic                  issue_s;
  logic                  last_issue_s;
  logic                  pop_s;
  logic                  last_hs_s;
  logic                  fifo_valid_s;
  pix_beat_t             fifo_beat_s;
  logic [1:0]            fifo_free_s;

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; flush wins over every other transition.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (i_start && !i_flush) state_nxt_s = ST_READ;
        else                     state_nxt_s = ST_IDLE;
      end
      ST_READ: begin
        if (i_flush)           state_nxt_s = ST_IDLE;
        else if (last_issue_s) state_nxt_s = ST_DRAIN;
        else                   state_nxt_s = ST_READ;
      end
      ST_DRAIN: begin
        if (i_flush)        state_nxt_s = ST_IDLE;
        else if (last_hs_s) state_nxt_s = ST_IDLE;
        else                state_nxt_s = ST_DRAIN;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM outputs: read issue and end-of-frame handshake detection.
  always_comb begin
    // Issue only when the word returning next cycle is guaranteed a slot,
    // counting the word already in flight and this cycle's pop.
    issue_s      = (state_r == ST_READ) && !i_flush && (fifo_free_s > {1'b0, inflight_r});
    last_issue_s = issue_s && (raddr_r == LAST_ADDR);
    pop_s        = fifo_valid_s && i_tready;
    // While draining nothing new is requested, so the last beat is the one
    // popped when the FIFO holds one entry (free becomes 2) and nothing is in flight.
    last_hs_s    = (state_r == ST_DRAIN) && pop_s && !inflight_r && (fifo_free_s == 2'd2);
  end

  // Address, raster counters, in-flight tracking and status flags.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      raddr_r        <= '0;
      x_r            <= '0;
      y_r            <= '0;
      inflight_r     <= 1'b0;
      inflight_sof_r <= 1'b0;
      inflight_eol_r <= 1'b0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
    end else if (i_flush) begin
      raddr_r        <= '0;
      x_r            <= '0;
      y_r            <= '0;
      inflight_r     <= 1'b0;
      inflight_sof_r <= 1'b0;
      inflight_eol_r <= 1'b0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
    end else begin
      // Sideband is decided at issue time and rides alongside the BRAM latency.
      inflight_r     <= issue_s;
      inflight_sof_r <= issue_s && (x_r == '0) && (y_r == '0);
      inflight_eol_r <= issue_s && (x_r == X_LAST);
      busy_r         <= (state_nxt_s != ST_IDLE);
      done_r         <= last_hs_s;
      if (issue_s) begin
        // Address returns to 0 after the last pixel so it never leaves the frame.
        raddr_r <= last_issue_s ? '0 : raddr_r + ADDR_WIDTH'(1);
        if (x_r == X_LAST) begin
          x_r <= '0;
          y_r <= (y_r == Y_LAST) ? '0 : y_r + Y_W'(1);
        end else begin
          x_r <= x_r + X_W'(1);
        end
      end
    end
  end

  pix_skid_fifo u_fifo (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_clr      (i_flush),
    .i_wr_en    (inflight_r),
    .i_wr_beat  (make_beat(PIX_W'(i_rdata), inflight_sof_r, inflight_eol_r)),
    .i_rd_ready (i_tready),
    .o_rd_valid (fifo_valid_s),
    .o_rd_beat  (fifo_beat_s),
    .o_free     (fifo_free_s)
  );

  assign o_raddr  = raddr_r;
  assign o_tvalid = fifo_valid_s;
  assign o_tdata  = DATA_WIDTH'(fifo_beat_s.data);
  assign o_tuser  = fifo_beat_s.sof;
  assign o_tlast  = fifo_beat_s.eol;
  assign o_busy   = busy_r;
  assign o_done   = done_r;

endmodule

// File: tb/tb_fbuf_reader.sv
// Bench for fbuf_reader on a reduced 16x8 frame. A BRAM model returns
// mem[a] = a ^ 16'hA5A5 one cycle after the address; expected beats are queued
// when a frame is started and popped on every output handshake.
module tb_fbuf_reader;

  localparam int DW = 16;
  localparam int H  = 16;
  localparam int V  = 8;
  localparam int AW = 8;
  localparam int FP = H * V;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic          flush;
  logic [AW-1:0] raddr;
  logic [DW-1:0] rdata;
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;
  logic          tuser;
  logic          tlast;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  fbuf_reader #(
    .DATA_WIDTH (DW),
    .H_ACTIVE   (H),
    .V_ACTIVE   (V),
    .ADDR_WIDTH (AW)
  ) dut (
    .i_clk    (clk),
    .i_rstn   (rstn),
    .i_start  (start),
    .i_flush  (flush),
    .o_raddr  (raddr),
    .i_rdata  (rdata),
    .o_tdata  (tdata),
    .o_tvalid (tvalid),
    .i_tready (tready),
    .o_tuser  (tuser),
    .o_tlast  (tlast),
    .o_busy   (busy),
    .o_done   (done)
  );

  function automatic logic [15:0] exp_pix(input int a);
    return 16'(a) ^ 16'hA5A5;
  endfunction

  // BRAM model: registered read.
  always @(posedge clk) rdata <= exp_pix(int'(raddr));

  typedef struct packed {
    logic [15:0] d;
    logic        u;
    logic        l;
  } exp_t;

  exp_t sb[$];
  int total, bad, cyc, hs_cnt, done_cnt, done_cyc, tlast_cnt, tuser_cnt;
  logic prev_stall, prev_flush, prev_user, prev_last;
  logic [DW-1:0] prev_data;

  // One clock: sample at negedge (scoreboard, stall hold, address bound), return at posedge+1.
  task automatic run_cycle();
    exp_t e;
    @(negedge clk);
    if (!rstn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && !prev_flush) begin
        total++;
        if (tvalid !== 1'b1 || tdata !== prev_data || tuser !== prev_user || tlast !== prev_last) begin
          bad++;
          $display("FAIL stall_hold: got v=%b d=%h u=%b l=%b, want v=1 d=%h u=%b l=%b",
                   tvalid, tdata, tuser, tlast, prev_data, prev_user, prev_last);
        end
      end
      total++;
      if (raddr > AW'(FP - 1)) begin
        bad++;
        $display("FAIL raddr_bound: got %0d, want <= %0d", raddr, FP - 1);
      end
      if (tvalid && tready) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_beat: got d=%h u=%b l=%b, want no beat", tdata, tuser, tlast);
        end else begin
          e = sb.pop_front();
          if ({tdata, tuser, tlast} !== {e.d, e.u, e.l}) begin
            bad++;
            $display("FAIL beat_%0d: got d=%h u=%b l=%b, want d=%h u=%b l=%b",
                     hs_cnt, tdata, tuser, tlast, e.d, e.u, e.l);
          end
        end
        hs_cnt++;
        if (tlast) tlast_cnt++;
        if (tuser) tuser_cnt++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = tvalid && !tready;
      prev_data  = tdata;
      prev_user  = tuser;
      prev_last  = tlast;
      prev_flush = flush;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Queue the expected frame and pulse i_start; returns just after the sampling edge (cyc = 0).
  task automatic kick();
    for (int i = 0; i < FP; i++) sb.push_back('{d: exp_pix(i), u: (i == 0), l: ((i % H) == H - 1)});
    hs_cnt = 0; tlast_cnt = 0; tuser_cnt = 0; done_cnt = 0; done_cyc = -1;
    start = 1'b1;
    run_cycle();
    start = 1'b0;
    cyc = 0;
  endtask

  // Run with the current i_tready until n beats have handshaked.
  task automatic wait_beats(input int n);
    for (int k = 0; k < FP * 4 && hs_cnt < n; k++) run_cycle();
    total++;
    if (hs_cnt != n) begin
      bad++;
      $display("FAIL wait_beats: got %0d beats, want %0d", hs_cnt, n);
    end
  endtask

  // Drain the remainder of a frame and check its totals.
  task automatic finish_frame(input string tag, input bit rnd);
    for (int k = 0; k < FP * 8 && done_cnt == 0; k++) begin
      tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      run_cycle();
    end
    tready = 1'b1;
    repeat (4) run_cycle();
    total++;
    if (done_cnt != 1) begin
      bad++;
      $display("FAIL %s_done_count: got %0d, want 1", tag, done_cnt);
    end
    total++;
    if (hs_cnt != FP || sb.size() != 0) begin
      bad++;
      $display("FAIL %s_beats: got %0d beats (%0d left), want %0d (0 left)", tag, hs_cnt, sb.size(), FP);
    end
    total++;
    if (tlast_cnt != V || tuser_cnt != 1) begin
      bad++;
      $display("FAIL %s_markers: got tlast=%0d tuser=%0d, want tlast=%0d tuser=1", tag, tlast_cnt, tuser_cnt, V);
    end
    total++;
    if (busy !== 1'b0 || tvalid !== 1'b0) begin
      bad++;
      $display("FAIL %s_idle: got busy=%b tvalid=%b, want 0 0", tag, busy, tvalid);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    #2;
    total++;
    if ({tvalid, tuser, tlast, busy, done} !== 5'b0 || tdata !== 16'h0000 || raddr !== 8'h00) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b u=%b l=%b busy=%b done=%b d=%h a=%h, want all 0",
               tvalid, tuser, tlast, busy, done, tdata, raddr);
    end
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (2) run_cycle();
    total++;
    if (busy !== 1'b0 || tvalid !== 1'b0 || raddr !== 8'h00) begin
      bad++;
      $display("FAIL reset_release: got busy=%b v=%b a=%h, want 0 0 00", busy, tvalid, raddr);
    end
  endtask

  task automatic test_full_frame();
    tready = 1'b1;
    kick();
    total++;
    if (tvalid !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL lat_edge0: got v=%b busy=%b, want v=0 busy=1", tvalid, busy);
    end
    run_cycle();
    total++;
    if (tvalid !== 1'b0) begin
      bad++;
      $display("FAIL lat_edge1: got v=%b, want 0", tvalid);
    end
    run_cycle();
    total++;
    if (tvalid !== 1'b1 || tdata !== 16'hA5A5 || tuser !== 1'b1) begin
      bad++;
      $display("FAIL lat_edge2: got v=%b d=%h u=%b, want v=1 d=a5a5 u=1", tvalid, tdata, tuser);
    end
    finish_frame("full", 1'b0);
    total++;
    if (done_cyc != FP + 2) begin
      bad++;
      $display("FAIL full_done_cycle: got %0d, want %0d", done_cyc, FP + 2);
    end
  endtask

  task automatic test_backpressure();
    tready = 1'b0;
    kick();
    finish_frame("bp", 1'b1);
  endtask

  task automatic test_mid_start();
    tready = 1'b1;
    kick();
    wait_beats(50);
    start = 1'b1;
    run_cycle();
    start = 1'b0;
    finish_frame("midstart", 1'b0);
  endtask

  task automatic test_flush();
    tready = 1'b1;
    kick();
    wait_beats(20);
    tready = 1'b0;
    repeat (2) run_cycle();
    flush = 1'b1;
    run_cycle();
    flush = 1'b0;
    sb.delete();
    total++;
    if (tvalid !== 1'b0 || raddr !== 8'h00 || busy !== 1'b0) begin
      bad++;
      $display("FAIL flush_state: got v=%b a=%h busy=%b, want 0 00 0", tvalid, raddr, busy);
    end
    tready = 1'b1;
    repeat (5) run_cycle();
    total++;
    if (done_cnt != 0 || tvalid !== 1'b0) begin
      bad++;
      $display("FAIL flush_quiet: got done=%0d v=%b, want 0 0", done_cnt, tvalid);
    end
    tready = 1'b0;
    kick();
    repeat (2) run_cycle();
    total++;
    if (tvalid !== 1'b1 || tdata !== 16'hA5A5 || tuser !== 1'b1) begin
      bad++;
      $display("FAIL flush_restart_beat0: got v=%b d=%h u=%b, want 1 a5a5 1", tvalid, tdata, tuser);
    end
    finish_frame("flush_restart", 1'b0);
  endtask

  task automatic test_reset_mid();
    tready = 1'b1;
    kick();
    wait_beats(70);
    #2;
    rstn = 1'b0;
    #1;
    total++;
    if ({tvalid, tuser, tlast, busy, done} !== 5'b0 || tdata !== 16'h0000 || raddr !== 8'h00) begin
      bad++;
      $display("FAIL midreset_outputs: got v=%b u=%b l=%b busy=%b done=%b d=%h a=%h, want all 0",
               tvalid, tuser, tlast, busy, done, tdata, raddr);
    end
    sb.delete();
    repeat (3) run_cycle();
    rstn = 1'b1;
    run_cycle();
    kick();
    finish_frame("reset_restart", 1'b0);
  endtask

  task automatic test_line_wrap();
    tready = 1'b1;
    kick();
    wait_beats(H - 1);
    tready = 1'b0;
    repeat (3) begin
      run_cycle();
      total++;
      if (tvalid !== 1'b1 || tlast !== 1'b1 || tdata !== exp_pix(H - 1)) begin
        bad++;
        $display("FAIL wrap_hold: got v=%b l=%b d=%h, want 1 1 %h", tvalid, tlast, tdata, exp_pix(H - 1));
      end
    end
    tready = 1'b1;
    run_cycle();
    total++;
    if (tvalid !== 1'b1 || tlast !== 1'b0 || tdata !== exp_pix(H)) begin
      bad++;
      $display("FAIL wrap_next: got v=%b l=%b d=%h, want 1 0 %h", tvalid, tlast, tdata, exp_pix(H));
    end
    finish_frame("wrap", 1'b0);
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; flush = 1'b0; tready = 1'b0;
    total = 0; bad = 0; cyc = 0; hs_cnt = 0; done_cnt = 0; done_cyc = -1;
    tlast_cnt = 0; tuser_cnt = 0;
    prev_stall = 1'b0; prev_flush = 1'b0; prev_user = 1'b0; prev_last = 1'b0; prev_data = '0;
    test_reset();
    test_full_frame();
    test_backpressure();
    test_mid_start();
    test_flush();
    test_reset_mid();
    test_line_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
